// File: rtl/fifo_syn_ex.sv
// fifo_syn_ex -- parametrised single-clock FIFO.
//   Fill count, programmable almost-full / almost-empty, sticky
//   overflow / underflow, synchronous flush.
//   Optional first-word-fall-through read port, enabled by defining the
//   macro FIFO_FWFT_EN. When it is left undefined, q is registered.
// Ports:
//   clk, rst (async, active-high), clr (sync flush)
//   wr, data            write side
//   rd, q               read side
//   full, empty, almost_full, almost_empty, usedw  status (registered count)
//   overflow, underflow sticky errors, cleared by err_clr
module fifo_syn_ex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [WIDTH-1:0]  data,
  input  logic              rd,
  output logic [WIDTH-1:0]  q,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W+1)'(AE_LEVEL);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_usedw;
  logic              r_ovf, r_udf;
  logic              w_rd_acc, w_wr_acc;

  // Flags come only from the count register, never from wr/rd.
  assign full         = (r_usedw == CNT_FULL);
  assign empty        = (r_usedw == '0);
  assign almost_full  = (r_usedw >= CNT_AF);
  assign almost_empty = (r_usedw <= CNT_AE);
  assign usedw        = r_usedw;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // A write into a full FIFO is still taken when a read frees a slot
  // on the same edge.
  assign w_rd_acc = rd & ~empty;
  assign w_wr_acc = wr & (~full | w_rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_usedw <= r_usedw + (ADDR_W+1)'(1);
        2'b01:   r_usedw <= r_usedw - (ADDR_W+1)'(1);
        default: r_usedw <= r_usedw;
      endcase
    end
  end

  // Storage is not reset; flush does not write it.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !clr) r_mem[r_wr_ptr] <= data;
  end

  // Sticky errors: a set on the same edge as err_clr takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr && !w_wr_acc) r_ovf <= 1'b1;
      else if (err_clr)    r_ovf <= 1'b0;
      if (rd && empty)     r_udf <= 1'b1;
      else if (err_clr)    r_udf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; meaningless while empty.
  assign q = r_mem[r_rd_ptr];
`else
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_q <= '0;
    else if (w_rd_acc && !clr) r_q <= r_mem[r_rd_ptr];
  end
  assign q = r_q;
`endif

endmodule

// File: tb/tb_fifo_syn_ex.sv
module tb_fifo_syn_ex;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0, wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] q;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] usedw;

  int checks = 0;
  int errors = 0;

  // scoreboard / reference state
  logic [7:0] sb[$];
  logic [7:0] m_q = '0;
  logic       m_ovf = 1'b0, m_udf = 1'b0;

  fifo_syn_ex #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .data(data), .rd(rd), .q(q),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .usedw(usedw), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against the reference state.
  task automatic chk_all(input string tag);
    int n;
    n = sb.size();
    chk({tag, " usedw"}, 32'(usedw), 32'(n));
    chk({tag, " empty"}, 32'(empty), 32'(n == 0));
    chk({tag, " full"},  32'(full),  32'(n == 4));
    chk({tag, " af"},    32'(almost_full),  32'(n >= 3));
    chk({tag, " ae"},    32'(almost_empty), 32'(n <= 1));
    chk({tag, " ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, " udf"},   32'(underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    if (n > 0) chk({tag, " q"}, 32'(q), 32'(sb[0]));
`else
    chk({tag, " q"}, 32'(q), 32'(m_q));
`endif
  endtask

  // One clock: drive at negedge, update reference, check 1ns after posedge.
  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic r, input logic c, input logic ec);
    logic racc, wacc;
    @(negedge clk);
    wr = w; data = d; rd = r; clr = c; err_clr = ec;
    racc = r && sb.size() != 0;
    wacc = w && (sb.size() != 4 || racc);
    if (w && !wacc)                m_ovf = 1'b1;
    else if (ec)                   m_ovf = 1'b0;
    if (r && sb.size() == 0)       m_udf = 1'b1;
    else if (ec)                   m_udf = 1'b0;
    if (c) sb.delete();
    else begin
      if (racc) m_q = sb.pop_front();
      if (wacc) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    sb.delete(); m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    logic [7:0] v4 [4];
    v4[0] = 8'hab; v4[1] = 8'h12; v4[2] = 8'h34; v4[3] = 8'h56;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk); rst = 1'b0;

    // 1: fill then overflow
    for (int i = 0; i < 4; i++) step("fill", 1'b1, v4[i], 1'b0, 1'b0, 1'b0);
    step("ovf_wr", 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);

`ifndef FIFO_FWFT_EN
    // 2: drain, underflow, error clear
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_q", 32'(q), 32'(v4[i]));
    end
    step("udf_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("udf_q_hold", 32'(q), 32'h56);
    step("err_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("err_cleared", 32'({overflow, underflow}), 32'd0);

    // 3: simultaneous write+read at full
    for (int i = 0; i < 4; i++) step("refill", 1'b1, v4[i], 1'b0, 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 8'h9c, 1'b1, 1'b0, 1'b0);
    chk("full_wr_rd_q", 32'(q), 32'hab);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("9c_last", 32'(q), 32'h9c);

    // 4: wrap-around with one entry in flight
    step("wrap_w0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step("wrap", 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    step("wrap_last", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_q9", 32'(q), 32'h09);
`else
    // 5: first-word-fall-through
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("err_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("fwft_w", 1'b1, 8'h5a, 1'b0, 1'b0, 1'b0);
    chk("fwft_q", 32'(q), 32'h5a);
    step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fwft_empty", 32'(empty), 32'd1);
`endif

    // 6: flush keeps overflow
    for (int i = 0; i < 5; i++) step("pre_clr", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("pre_clr_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("clr", 1'b1, 8'hee, 1'b1, 1'b1, 1'b0);
    chk("clr_ovf_kept", 32'(overflow), 32'd1);
    chk("clr_usedw", 32'(usedw), 32'd0);

    // 6: async reset mid-burst
    step("burst", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step("burst", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr = 1'b0; err_clr = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_all("mid_rst");
    @(negedge clk); rst = 1'b0;

    // post-reset sanity
    step("post_w", 1'b1, 8'hc3, 1'b0, 1'b0, 1'b0);
    step("post_r", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("post_q", 32'(q), 32'hc3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
